// File: rtl/bp_table_arbiter.sv
// Predictor table sequencer: post-reset init sweep, lookup/update arbitration.
// Optional define BP_UPD_FWD_EN adds fwd_* bypass of queued updates to lookups.
module bp_table_arbiter #(
  parameter int IDX_W      = 8,
  parameter int QDEPTH     = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       lookup_req,
  input  logic [IDX_W-1:0]           lookup_idx,
  output logic                       lookup_grant,
  output logic                       lookup_stall,
  input  logic                       upd_valid,
  input  logic [IDX_W-1:0]           upd_idx,
  input  logic [1:0]                 upd_ctr,
  input  logic [15:0]                upd_target,
  output logic                       upd_ready,
  output logic                       tbl_en,
  output logic                       tbl_we,
  output logic [IDX_W-1:0]           tbl_idx,
  output logic [1:0]                 tbl_wctr,
  output logic [15:0]                tbl_wtarget,
  output logic [$clog2(QDEPTH):0]    q_count,
  output logic                       init_done
`ifdef BP_UPD_FWD_EN
  ,
  output logic                       fwd_hit,
  output logic [1:0]                 fwd_ctr,
  output logic [15:0]                fwd_target
`endif
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [IDX_W-1:0] r_init_cnt;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [SW-1:0]    r_starve;
  logic [IDX_W-1:0] r_q_idx [QDEPTH];
  logic [1:0]       r_q_ctr [QDEPTH];
  logic [15:0]      r_q_tgt [QDEPTH];
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(QDEPTH));
  assign w_pop   = (r_state == ST_RUN) && !w_empty &&
                   (!lookup_req || w_full ||
                    r_starve == SW'(STARVE_MAX));
  assign w_push  = upd_valid && upd_ready;
  assign q_count = r_count;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_INIT;
    else       r_state <= w_next;
  end

  // Next state and table port / handshake outputs
  always_comb begin
    w_next       = r_state;
    lookup_grant = 1'b0;
    upd_ready    = 1'b0;
    init_done    = 1'b0;
    tbl_en       = 1'b0;
    tbl_we       = 1'b0;
    tbl_idx      = '0;
    tbl_wctr     = 2'b00;
    tbl_wtarget  = 16'h0000;
    case (r_state)
      ST_INIT: begin
        tbl_en   = 1'b1;
        tbl_we   = 1'b1;
        tbl_idx  = r_init_cnt;
        tbl_wctr = 2'b01;
        if (r_init_cnt == {IDX_W{1'b1}}) w_next = ST_RUN;
      end
      ST_RUN: begin
        init_done = 1'b1;
        upd_ready = !w_full;
        if (w_pop) begin
          tbl_en      = 1'b1;
          tbl_we      = 1'b1;
          tbl_idx     = r_q_idx[r_rd_ptr];
          tbl_wctr    = r_q_ctr[r_rd_ptr];
          tbl_wtarget = r_q_tgt[r_rd_ptr];
        end else if (lookup_req) begin
          tbl_en       = 1'b1;
          tbl_idx      = lookup_idx;
          lookup_grant = 1'b1;
        end
      end
      default: w_next = ST_INIT;
    endcase
  end

  assign lookup_stall = lookup_req && !lookup_grant;

  // Sweep index walks the whole table once after reset
  always_ff @(posedge clk) begin
    if (reset)                   r_init_cnt <= '0;
    else if (r_state == ST_INIT) r_init_cnt <= r_init_cnt + 1'b1;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // FIFO payload storage, no reset needed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_idx[r_wr_ptr] <= upd_idx;
      r_q_ctr[r_wr_ptr] <= upd_ctr;
      r_q_tgt[r_wr_ptr] <= upd_target;
    end
  end

  // Count lookup wins while updates wait, so updates cannot starve
  always_ff @(posedge clk) begin
    if (reset)
      r_starve <= '0;
    else if (w_pop || w_empty)
      r_starve <= '0;
    else if (lookup_grant && r_starve != SW'(STARVE_MAX))
      r_starve <= r_starve + 1'b1;
  end

`ifdef BP_UPD_FWD_EN
  // Youngest queued update to the looked-up index bypasses the stale table
  always_comb begin
    fwd_hit    = 1'b0;
    fwd_ctr    = 2'b00;
    fwd_target = 16'h0000;
    for (int k = 0; k < QDEPTH; k++) begin
      if (lookup_grant && (CW'(k) < r_count) &&
          !(w_pop && k == 0) &&
          r_q_idx[r_rd_ptr + PW'(k)] == lookup_idx) begin
        fwd_hit    = 1'b1;
        fwd_ctr    = r_q_ctr[r_rd_ptr + PW'(k)];
        fwd_target = r_q_tgt[r_rd_ptr + PW'(k)];
      end
    end
  end
`endif

endmodule

// File: tb/tb_bp_table_arbiter.sv
// Bench for bp_table_arbiter: queue-based reference model plus directed cases.
// Build with BP_UPD_FWD_EN to also cover the forwarding outputs.
module tb_bp_table_arbiter;

  localparam int QD = 4;
  localparam int SM = 3;

  typedef struct packed {
    logic [7:0]  idx;
    logic [1:0]  ctr;
    logic [15:0] tgt;
  } ent_t;

  logic        clk;
  logic        reset;
  logic        lookup_req;
  logic [7:0]  lookup_idx;
  logic        lookup_grant;
  logic        lookup_stall;
  logic        upd_valid;
  logic [7:0]  upd_idx;
  logic [1:0]  upd_ctr;
  logic [15:0] upd_target;
  logic        upd_ready;
  logic        tbl_en;
  logic        tbl_we;
  logic [7:0]  tbl_idx;
  logic [1:0]  tbl_wctr;
  logic [15:0] tbl_wtarget;
  logic [2:0]  q_count;
  logic        init_done;
`ifdef BP_UPD_FWD_EN
  logic        fwd_hit;
  logic [1:0]  fwd_ctr;
  logic [15:0] fwd_target;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bp_table_arbiter #(.IDX_W(8), .QDEPTH(QD), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .lookup_req(lookup_req), .lookup_idx(lookup_idx),
    .lookup_grant(lookup_grant), .lookup_stall(lookup_stall),
    .upd_valid(upd_valid), .upd_idx(upd_idx),
    .upd_ctr(upd_ctr), .upd_target(upd_target),
    .upd_ready(upd_ready),
    .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_idx(tbl_idx),
    .tbl_wctr(tbl_wctr), .tbl_wtarget(tbl_wtarget),
    .q_count(q_count), .init_done(init_done)
`ifdef BP_UPD_FWD_EN
    , .fwd_hit(fwd_hit), .fwd_ctr(fwd_ctr), .fwd_target(fwd_target)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: sweep position, run flag, queue of pending updates
  bit   m_valid = 0;
  bit   m_run;
  int   m_init;
  int   m_starve;
  ent_t m_q[$];
  ent_t m_ret[$];

  always @(negedge clk) begin
    int   sz;
    bit   e_pop;
    bit   e_grant;
    bit   e_hit;
    ent_t e_f;
    sz = m_q.size();
    e_pop = 0;
    e_grant = 0;
    if (m_run) begin
      e_pop = (sz > 0) && (!lookup_req || sz == QD || m_starve == SM);
      e_grant = lookup_req && !e_pop;
    end
    if (m_valid) begin
      check("q_count", q_count, sz);
      check("init_done", init_done, m_run);
      check("grant", lookup_grant, e_grant);
      check("stall", lookup_stall, lookup_req && !e_grant);
      if (!m_run) begin
        check("en", tbl_en, 1);
        check("we", tbl_we, 1);
        check("sweep_idx", tbl_idx, m_init);
        check("sweep_ctr", tbl_wctr, 1);
        check("sweep_tgt", tbl_wtarget, 0);
        check("ready", upd_ready, 0);
      end else begin
        check("en", tbl_en, e_pop || lookup_req);
        check("we", tbl_we, e_pop);
        check("ready", upd_ready, sz < QD);
        if (e_pop) begin
          check("pop_idx", tbl_idx, m_q[0].idx);
          check("pop_ctr", tbl_wctr, m_q[0].ctr);
          check("pop_tgt", tbl_wtarget, m_q[0].tgt);
        end else if (e_grant) begin
          check("rd_idx", tbl_idx, lookup_idx);
        end
      end
`ifdef BP_UPD_FWD_EN
      e_hit = 0;
      e_f = '0;
      if (e_grant)
        for (int k = 0; k < sz; k++)
          if (m_q[k].idx == lookup_idx) begin
            e_hit = 1;
            e_f = m_q[k];
          end
      check("fwd_hit", fwd_hit, e_hit);
      if (e_hit) begin
        check("fwd_ctr", fwd_ctr, e_f.ctr);
        check("fwd_tgt", fwd_target, e_f.tgt);
      end
`endif
    end
    if (reset) begin
      m_valid = 1;
      m_run = 0;
      m_init = 0;
      m_starve = 0;
      m_q.delete();
    end else if (m_valid) begin
      if (!m_run) begin
        if (m_init == 255) m_run = 1;
        m_init++;
      end else begin
        if (e_pop || sz == 0) m_starve = 0;
        else if (e_grant && m_starve < SM) m_starve++;
        if (e_pop) begin
          m_ret.push_back(m_q[0]);
          void'(m_q.pop_front());
        end
        if (upd_valid && sz < QD)
          m_q.push_back({upd_idx, upd_ctr, upd_target});
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic v, input logic [7:0] i,
                     input logic [1:0] c, input logic [15:0] t);
    upd_valid = v;
    upd_idx = i;
    upd_ctr = c;
    upd_target = t;
  endtask

  initial begin
    reset = 1;
    lookup_req = 0;
    lookup_idx = 0;
    upd(0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 0;

    // Sweep: writes 0..255 of 01/0000, lookups stalled
    lookup_req = 1;
    lookup_idx = 8'h55;
    for (int i = 0; i < 256; i++) begin
      #3;
      check("t1_idx", tbl_idx, i);
      check("t1_we", tbl_we, 1);
      check("t1_grant", lookup_grant, 0);
      nxt();
    end
    #3;
    check("t1_done", init_done, 1);
    nxt();

    // One update vs constant lookups: 3 grants then forced pop
    upd(1, 8'h3C, 2'b11, 16'h1234);
    #3;
    check("t2_g0", lookup_grant, 1);
    nxt();
    upd(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #3;
      check("t2_grant", lookup_grant, 1);
      nxt();
    end
    #3;
    check("t2_we", tbl_we, 1);
    check("t2_idx", tbl_idx, 8'h3C);
    check("t2_ctr", tbl_wctr, 2'b11);
    check("t2_tgt", tbl_wtarget, 16'h1234);
    check("t2_stall", lookup_stall, 1);
    nxt();
    #3;
    check("t2_empty", q_count, 0);
    nxt();

    // Fill to 4, drop an update while full, then full override
    for (int i = 0; i < 4; i++) begin
      upd(1, 8'h40 + 8'(i), 2'(i), 16'h4000 + 16'(i));
      nxt();
    end
    upd(1, 8'h44, 2'b00, 16'h4444);
    #3;
    check("t3_cnt4", q_count, 4);
    check("t3_rdy0", upd_ready, 0);
    check("t3_pop", tbl_we, 1);
    check("t3_pidx", tbl_idx, 8'h40);
    nxt();
    upd(1, 8'h45, 2'b01, 16'h4545);
    #3;
    check("t3_rdy1", upd_ready, 1);
    check("t3_cnt3", q_count, 3);
    check("t3_grant", lookup_grant, 1);
    nxt();
    upd(0, 0, 0, 0);
    #3;
    check("t3_full_cnt", q_count, 4);
    check("t3_full_we", tbl_we, 1);
    check("t3_full_g", lookup_grant, 0);
    check("t3_full_idx", tbl_idx, 8'h41);
    nxt();
    lookup_req = 0;
    for (int i = 0; i < 3; i++) nxt();
    #3;
    check("t3_drained", q_count, 0);
    nxt();

    // Simultaneous enqueue and pop at count 2, order preserved
    m_ret.delete();
    lookup_req = 1;
    upd(1, 8'h50, 2'b10, 16'h5050);
    nxt();
    upd(1, 8'h51, 2'b01, 16'h5151);
    #3;
    check("t4_cnt1", q_count, 1);
    nxt();
    lookup_req = 0;
    upd(1, 8'h52, 2'b11, 16'h5252);
    #3;
    check("t4_cnt2a", q_count, 2);
    check("t4_p0", tbl_idx, 8'h50);
    nxt();
    upd(0, 0, 0, 0);
    #3;
    check("t4_cnt2b", q_count, 2);
    check("t4_p1", tbl_idx, 8'h51);
    nxt();
    #3;
    check("t4_p2", tbl_idx, 8'h52);
    nxt();
    #3;
    check("t4_cnt0", q_count, 0);
    check("t4_nret", m_ret.size(), 3);
    if (m_ret.size() == 3) begin
      check("t4_r0", m_ret[0].idx, 8'h50);
      check("t4_r1", m_ret[1].idx, 8'h51);
      check("t4_r2", m_ret[2].idx, 8'h52);
    end
    nxt();

    // Reset with three updates queued
    lookup_req = 1;
    for (int i = 0; i < 3; i++) begin
      upd(1, 8'h60 + 8'(i), 2'b10, 16'h6000);
      nxt();
    end
    upd(0, 0, 0, 0);
    reset = 1;
    #3;
    check("t5_cnt3", q_count, 3);
    nxt();
    reset = 0;
    #3;
    check("t5_cnt0", q_count, 0);
    check("t5_done0", init_done, 0);
    check("t5_we", tbl_we, 1);
    check("t5_idx", tbl_idx, 0);
    check("t5_ctr", tbl_wctr, 2'b01);
    check("t5_tgt", tbl_wtarget, 0);
    check("t5_grant", lookup_grant, 0);
    for (int i = 0; i < 256; i++) nxt();
    #3;
    check("t5_done1", init_done, 1);
    nxt();

`ifdef BP_UPD_FWD_EN
    // Youngest queued update forwards to a matching lookup
    lookup_req = 1;
    lookup_idx = 8'h10;
    upd(1, 8'h10, 2'b10, 16'hAAAA);
    #3;
    check("t6_nohit", fwd_hit, 0);
    nxt();
    upd(1, 8'h10, 2'b11, 16'hBBBB);
    #3;
    check("t6_hit1", fwd_hit, 1);
    check("t6_ctr1", fwd_ctr, 2'b10);
    nxt();
    upd(0, 0, 0, 0);
    #3;
    check("t6_hit2", fwd_hit, 1);
    check("t6_ctr2", fwd_ctr, 2'b11);
    check("t6_tgt2", fwd_target, 16'hBBBB);
    nxt();
    lookup_req = 0;
    for (int i = 0; i < 3; i++) nxt();
`endif

    lookup_req = 0;
    for (int i = 0; i < 4; i++) nxt();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
